// File: rtl/jump_ctrl_pkg.sv
// Shared types and defaults for the branch/jump control unit.
package jump_ctrl_pkg;

    localparam int D_DEFAULT = 12;

    typedef enum logic [2:0] {
        COND_AL = 3'd0,
        COND_EQ = 3'd1,
        COND_NE = 3'd2,
        COND_MI = 3'd3,
        COND_PL = 3'd4,
        COND_CS = 3'd5,
        COND_CC = 3'd6,
        COND_NV = 3'd7
    } cond_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } state_e;

endpackage

// File: rtl/jump_lut.sv
// Jump target/offset register file: async reset, synchronous write,
// combinational read that returns the pre-write value on a same-cycle collision.
module jump_lut
    import jump_ctrl_pkg::*;
#(
    parameter int D         = D_DEFAULT,
    parameter int LUT_DEPTH = 16,
    parameter int LW        = $clog2(LUT_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [LW-1:0] waddr,
    input  logic [D-1:0]  wdata,
    input  logic [LW-1:0] raddr,
    output logic [D-1:0]  rdata
);

    logic [D-1:0] mem [LUT_DEPTH];

    // NOTE: every entry is cleared by reset because a jump right after reset must see target 0, so this cannot map to reset-less RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jump_ctrl.sv
// Branch/jump control: evaluates conditions against latched flags, issues a
// one-cycle registered jump pulse and squashes for SHADOW_CYC cycles after it.
// Optional branch statistics counters are enabled with JUMP_CTRL_STATS_EN.
module jump_ctrl
    import jump_ctrl_pkg::*;
#(
    parameter int D          = D_DEFAULT,
    parameter int LUT_DEPTH  = 16,
    parameter int SHADOW_CYC = 1,
    localparam int LW        = $clog2(LUT_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          br_valid,
    input  logic [2:0]    br_cond,
    input  logic          br_rel,
    input  logic [LW-1:0] br_idx,
    input  logic          flag_we,
    input  logic          alu_zero,
    input  logic          alu_neg,
    input  logic          alu_carry,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic          branch_en,
    output logic          reljump_en,
    output logic          absjump_en,
    output logic [D-1:0]  target,
`ifdef JUMP_CTRL_STATS_EN
    output logic [15:0]   taken_cnt,
    output logic [15:0]   nottaken_cnt,
`endif
    output logic          squash
);

    state_e       state;
    logic [2:0]   shadow_cnt;
    logic         flag_z, flag_n, flag_c;
    logic [D-1:0] lut_rdata;
    logic         taken;
    logic         accept;
    cond_e        cond;

    jump_lut #(.D(D), .LUT_DEPTH(LUT_DEPTH), .LW(LW)) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (br_idx),
        .rdata (lut_rdata)
    );

    assign cond   = cond_e'(br_cond);
    assign accept = (state == IDLE) && br_valid;

    // NOTE: taken gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = flag_z;
            COND_NE: taken = !flag_z;
            COND_MI: taken = flag_n;
            COND_PL: taken = !flag_n;
            COND_CS: taken = flag_c;
            COND_CC: taken = !flag_c;
            COND_NV: taken = 1'b0;
        endcase
    end

    // NOTE: non-blocking assignments keep every register reading pre-edge values, so flags written this edge reach only later branches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else if (flag_we) begin
            flag_z <= alu_zero;
            flag_n <= alu_neg;
            flag_c <= alu_carry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shadow_cnt <= '0;
            branch_en  <= 1'b0;
            reljump_en <= 1'b0;
            absjump_en <= 1'b0;
            target     <= '0;
            squash     <= 1'b0;
        end else begin
            branch_en  <= 1'b0;
            reljump_en <= 1'b0;
            absjump_en <= 1'b0;
            target     <= '0;
            unique case (state)
                IDLE: begin
                    if (accept && taken) begin
                        branch_en  <= 1'b1;
                        reljump_en <= br_rel;
                        absjump_en <= !br_rel;
                        target     <= lut_rdata;
                        squash     <= 1'b1;
                        shadow_cnt <= 3'(SHADOW_CYC);
                        state      <= SHADOW;
                    end
                end
                SHADOW: begin
                    // The count reaching 0 marks the end of the last squash cycle.
                    shadow_cnt <= shadow_cnt - 3'd1;
                    if (shadow_cnt == 3'd1) begin
                        squash <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef JUMP_CTRL_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else if (accept) begin
            if (taken) begin
                if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
            end else begin
                if (nottaken_cnt != 16'hFFFF) nottaken_cnt <= nottaken_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
